// File: rtl/logic_probe_trigger_if.sv
// Signal bundle between the logic probe sampler side and the trigger front end.
// The master drives channels and trigger configuration; the slave returns aligned data and strobes.
interface logic_probe_trigger_if #(
    parameter int WIDTH = 128,
    parameter int CNTW  = 16
);
    logic             arm;
    logic [WIDTH-1:0] channels;
    logic [WIDTH-1:0] match_mask;
    logic [WIDTH-1:0] match_value;
    logic [WIDTH-1:0] edge_mask;
    logic [CNTW-1:0]  occurrences;
    logic [CNTW-1:0]  delay;
    logic [CNTW-1:0]  sample_div;
    logic [WIDTH-1:0] channels_out;
    logic             trigger;
    logic             sample;
    logic [1:0]       status;

    modport master (
        output arm, channels, match_mask, match_value, edge_mask,
               occurrences, delay, sample_div,
        input  channels_out, trigger, sample, status
    );

    modport slave (
        input  arm, channels, match_mask, match_value, edge_mask,
               occurrences, delay, sample_div,
        output channels_out, trigger, sample, status
    );
endinterface

// File: rtl/logic_probe_trigger.sv
// Probe front end: registers the channels, searches for a mask/value/edge match with occurrence
// counting and post-match delay, and drives a one-shot trigger plus a free-running sample strobe.
module logic_probe_trigger #(
    parameter int WIDTH = 128,
    parameter int CNTW  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    logic_probe_trigger_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        FIRED = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ch_q;
    logic [WIDTH-1:0] ch_qq;
    logic [WIDTH-1:0] chout_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] edge_q;
    logic [CNTW-1:0]  delay_q;
    logic [CNTW-1:0]  occ_cnt_q;
    logic [CNTW-1:0]  dly_cnt_q;
    logic [CNTW-1:0]  div_cnt_q;
    logic             trigger_q;
    logic             sample_q;

    logic [WIDTH-1:0] bit_ok_s;
    logic             match_s;
    logic             arm_ok_s;
    logic [CNTW-1:0]  occ_load_s;

    // Per-bit compare: masked-off bits pass; edge bits must also have differed from value last cycle.
    always_comb begin
        bit_ok_s   = ~mask_q | (~(ch_q ^ value_q) & (~edge_q | (ch_qq ^ value_q)));
        match_s    = &bit_ok_s;
        arm_ok_s   = bus.arm && (state_q != FIRED);
        occ_load_s = (bus.occurrences == {CNTW{1'b0}}) ? {{(CNTW-1){1'b0}}, 1'b1}
                                                       : bus.occurrences;
    end

    // Channel pipeline; channels_out stays aligned with the registered trigger.
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_q    <= {WIDTH{1'b0}};
            ch_qq   <= {WIDTH{1'b0}};
            chout_q <= {WIDTH{1'b0}};
        end else begin
            ch_q    <= bus.channels;
            ch_qq   <= ch_q;
            chout_q <= ch_q;
        end
    end

    // Trigger configuration is captured only on an accepted arm.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q  <= {WIDTH{1'b0}};
            value_q <= {WIDTH{1'b0}};
            edge_q  <= {WIDTH{1'b0}};
            delay_q <= {CNTW{1'b0}};
        end else if (arm_ok_s) begin
            mask_q  <= bus.match_mask;
            value_q <= bus.match_value;
            edge_q  <= bus.edge_mask;
            delay_q <= bus.delay;
        end else begin
            mask_q  <= mask_q;
            value_q <= value_q;
            edge_q  <= edge_q;
            delay_q <= delay_q;
        end
    end

    // Trigger search state machine; an arm takes priority over any match in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            occ_cnt_q <= {CNTW{1'b0}};
            dly_cnt_q <= {CNTW{1'b0}};
            trigger_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ARMED, DELAY: begin
                    if (arm_ok_s) begin
                        state_q   <= ARMED;
                        occ_cnt_q <= occ_load_s;
                    end else if (state_q == ARMED && match_s) begin
                        if (occ_cnt_q > {{(CNTW-1){1'b0}}, 1'b1}) begin
                            occ_cnt_q <= occ_cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
                        end else if (delay_q == {CNTW{1'b0}}) begin
                            state_q   <= FIRED;
                            trigger_q <= 1'b1;
                        end else begin
                            state_q   <= DELAY;
                            dly_cnt_q <= delay_q;
                        end
                    end else if (state_q == DELAY) begin
                        if (dly_cnt_q <= {{(CNTW-1){1'b0}}, 1'b1}) begin
                            state_q   <= FIRED;
                            trigger_q <= 1'b1;
                        end else begin
                            dly_cnt_q <= dly_cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                FIRED: begin
                    trigger_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    trigger_q <= 1'b0;
                end
            endcase
        end
    end

    // Free-running sample strobe; sample_div is picked up only on reload.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= {CNTW{1'b0}};
            sample_q  <= 1'b0;
        end else if (div_cnt_q == {CNTW{1'b0}}) begin
            div_cnt_q <= bus.sample_div;
            sample_q  <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
            sample_q  <= 1'b0;
        end
    end

    assign bus.channels_out = chout_q;
    assign bus.trigger      = trigger_q;
    assign bus.sample       = sample_q;
    assign bus.status       = state_q;
endmodule

// File: tb/tb_logic_probe_trigger.sv
// Directed bench for logic_probe_trigger: a vector table for the basic trigger cases plus
// hand-written sequences for occurrence/delay, re-arm, sample strobe and mid-run reset.
module tb_logic_probe_trigger;
    localparam int WIDTH = 128;
    localparam int CNTW  = 16;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic_probe_trigger_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    logic_probe_trigger #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        arm;
        logic [7:0]  ch;
        logic [7:0]  mask;
        logic [7:0]  val;
        logic [7:0]  edg;
        logic [15:0] occ;
        logic [15:0] dly;
        logic [1:0]  st;
        logic        trig;
        logic [7:0]  chout;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] mask, input logic [7:0] val, input logic [7:0] edg,
                           input logic [15:0] occ, input logic [15:0] dly);
        bus.match_mask  = {120'd0, mask};
        bus.match_value = {120'd0, val};
        bus.edge_mask   = {120'd0, edg};
        bus.occurrences = occ;
        bus.delay       = dly;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.arm = 1'b0;
        bus.channels = {WIDTH{1'b0}};
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [1:0] st, input logic trig);
        check({name, "_status"},  {126'd0, bus.status}, {126'd0, st});
        check({name, "_trigger"}, {127'd0, bus.trigger}, {127'd0, trig});
    endtask

    initial begin
        logic [15:0] sexp;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.sample_div = 16'd0;
        set_cfg(8'h00, 8'h00, 8'h00, 16'd0, 16'd0);

        // rst arm ch mask val edg occ dly | st trig chout
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h5A, 8'h00, 16'd1, 16'd0, 2'd1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h5A, 8'h00, 16'd1, 16'd0, 2'd1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h5A, 8'hFF, 8'h5A, 8'h00, 16'd1, 16'd0, 2'd1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h5A, 8'h00, 16'd1, 16'd0, 2'd3, 1'b1, 8'h5A};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h5A, 8'h00, 16'd1, 16'd0, 2'd3, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd0, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd1, 1'b0, 8'h01};
        vecs[8]  = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd1, 1'b0, 8'h01};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd1, 1'b0, 8'h01};
        vecs[10] = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd1, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 16'd1, 16'd0, 2'd3, 1'b1, 8'h01};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 16'd0, 16'd0, 2'd0, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 16'd0, 16'd0, 2'd1, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 16'd0, 16'd0, 2'd3, 1'b1, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 16'd0, 16'd0, 2'd3, 1'b1, 8'h00};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 16'd0, 16'd0, 2'd0, 1'b0, 8'h00};

        do_reset();
        check_outs("reset", 2'd0, 1'b0);
        check("reset_sample", {127'd0, bus.sample}, {WIDTH{1'b0}});
        check("reset_chout", bus.channels_out, {WIDTH{1'b0}});

        for (int i = 0; i < 17; i++) begin
            reset        = vecs[i].rst;
            bus.arm      = vecs[i].arm;
            bus.channels = {120'd0, vecs[i].ch};
            set_cfg(vecs[i].mask, vecs[i].val, vecs[i].edg, vecs[i].occ, vecs[i].dly);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].trig);
            check($sformatf("vec%0d_chout", i), bus.channels_out, {120'd0, vecs[i].chout});
        end
        reset   = 1'b0;
        bus.arm = 1'b0;

        // Three matches then a four-cycle delay.
        do_reset();
        set_cfg(8'hFF, 8'h5A, 8'h00, 16'd3, 16'd4);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            bus.channels = (k == 2 || k == 7 || k == 12) ? {120'd0, 8'h5A} : {WIDTH{1'b0}};
            step();
            if (k <= 12)      check_outs($sformatf("occdly_k%0d", k), 2'd1, 1'b0);
            else if (k <= 16) check_outs($sformatf("occdly_k%0d", k), 2'd2, 1'b0);
            else              check_outs($sformatf("occdly_k%0d", k), 2'd3, 1'b1);
        end

        // Re-arm after two of three matches, with a match in the arm cycle.
        do_reset();
        set_cfg(8'hFF, 8'h5A, 8'h00, 16'd3, 16'd0);
        bus.arm = 1'b1;
        step();
        for (int k = 0; k <= 16; k++) begin
            bus.arm      = (k == 6);
            bus.channels = (k == 1 || k == 3 || k == 5 || k == 8 || k == 10 || k == 12)
                           ? {120'd0, 8'h5A} : {WIDTH{1'b0}};
            step();
            if (k < 13) check_outs($sformatf("rearm_k%0d", k), 2'd1, 1'b0);
            else        check_outs($sformatf("rearm_k%0d", k), 2'd3, 1'b1);
        end
        bus.arm = 1'b0;

        // Sample strobe: divide by 4, then switch to every cycle.
        bus.sample_div = 16'd3;
        do_reset();
        sexp = 16'hFF11;
        for (int n = 1; n <= 16; n++) begin
            if (n == 7) bus.sample_div = 16'd0;
            step();
            check($sformatf("sample_n%0d", n), {127'd0, bus.sample}, {127'd0, sexp[n-1]});
        end

        // Reset while counting down the delay.
        set_cfg(8'h00, 8'h00, 8'h00, 16'd1, 16'd4);
        bus.channels = {WIDTH{1'b1}};
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        step();
        check_outs("dly_a", 2'd2, 1'b0);
        step();
        check_outs("dly_b", 2'd2, 1'b0);
        check("dly_chout", bus.channels_out, {WIDTH{1'b1}});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outs("midreset", 2'd0, 1'b0);
        check("midreset_sample", {127'd0, bus.sample}, {WIDTH{1'b0}});
        check("midreset_chout", bus.channels_out, {WIDTH{1'b0}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_probe_trigger.md
Name: logic_probe_trigger

Overview:
- Front-end stage feeding the on-chip logic probe's sampler.
- Registers the 128 probed channels and evaluates a programmable mask/value/edge trigger condition, with an occurrence counter and a post-match delay.
- Drives the probe's one-shot trigger input and a programmable-rate sample strobe.
- Outputs channels_out, trigger and sample cycle-aligned, so the matching word is the first word the sampler sees with trigger high.

Parameters:
WIDTH, 128, number of probed channels
CNTW, 16, width of occurrence, delay and sample-divider counters

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
arm  in  1  single-cycle pulse; latches config and (re)starts trigger search
channels  in  WIDTH  raw probed signals
match_mask  in  WIDTH  1 = bit participates in trigger compare
match_value  in  WIDTH  required value per participating bit
edge_mask  in  WIDTH  1 = participating bit must also have just changed to match_value
occurrences  in  CNTW  number of matches required (0 treated as 1)
delay  in  CNTW  clock cycles from final match to trigger (0 = none)
sample_div  in  CNTW  sample strobe every sample_div+1 cycles
channels_out  out  WIDTH  delayed channels, to sampler data input
trigger  out  1  to sampler trigger; held high once fired
sample  out  1  to sampler sample strobe
status  out  2  0 IDLE, 1 ARMED, 2 DELAY, 3 FIRED

Behaviour:
Reset values:
- ch_q, ch_qq and channels_out = 0; trigger = 0; sample = 0; status = IDLE.
- All counters = 0; latched config = 0.

Pipeline:
- Each cycle: ch_q <= channels; ch_qq <= ch_q; channels_out <= ch_q.
- channels-to-channels_out latency is 2 cycles.

Match (combinational on ch_q and ch_qq, using latched config):
- Per-bit condition:
  - mask = 0 -> true.
  - mask = 1, edge = 0 -> ch_q[i] == value[i].
  - mask = 1, edge = 1 -> ch_q[i] == value[i] and ch_qq[i] != value[i].
- match = AND of all bits. An all-zero mask matches every cycle.

State machine:
- IDLE:
  - On arm: latch match_mask, match_value, edge_mask and delay.
  - occ_cnt <= max(occurrences, 1); go to ARMED.
- ARMED, each cycle match = 1:
  - occ_cnt > 1 -> occ_cnt--.
  - occ_cnt == 1 and latched delay == 0 -> FIRED.
  - occ_cnt == 1 and latched delay != 0 -> DELAY, dly_cnt <= delay.
  - Cycles without a match are ignored; matches need not be consecutive.
- DELAY:
  - Each cycle dly_cnt--; when dly_cnt == 1, go to FIRED.
  - FIRED is entered exactly `delay` cycles after the final match cycle.
  - No match evaluation in this state.
- FIRED:
  - Terminal; exit only via reset (the sampler is one-shot).
- trigger = 1 iff state == FIRED (state is registered, so trigger is registered).
- Alignment:
  - With delay = 0, a match on ch_q in cycle t gives trigger = 1 in cycle t+1, with channels_out = that matching word.
  - With delay D, trigger first rises D cycles later, and channels_out is the word D cycles after the match.

Arm rules:
- arm in ARMED or DELAY: re-latch config, reload occ_cnt, go to ARMED; a match in the same cycle is ignored.
- arm in FIRED: ignored.
- arm in IDLE: a match in the arm cycle is not counted; evaluation starts the next cycle.
- Config inputs may change freely; only values latched at arm are used. Exception: sample_div is used live, see below.

Sample generator (free-running, independent of the state machine):
- If div_cnt == 0: sample <= 1; div_cnt <= sample_div.
- Else: sample <= 0; div_cnt <= div_cnt - 1.
- sample_div = 0 gives sample high every cycle after the first post-reset cycle.
- A change to sample_div takes effect at the next reload.

Reset mid-operation:
- Reset returns to IDLE, drops trigger, and clears all counters and pipeline registers in the same edge.

Test Plan:
- Level trigger, no delay: mask = 0xFF, value = 0x5A, occurrences = 1, delay = 0, arm, then drive channels 0x00,0x5A -> trigger rises exactly 2 cycles after 0x5A is applied; channels_out = 0x5A in that cycle; status = 3.
- Edge trigger: mask = edge = bit0, value = 1; hold bit0 = 1 through arm -> no trigger; drop to 0, then raise to 1 -> trigger 2 cycles after the rising edge.
- Occurrence plus delay: occurrences = 3, delay = 4; match pulses at cycles 10, 15, 20 -> status 2 from cycle 21; trigger first high in cycle 25.
- occurrences = 0, mask = 0 -> fires on the first cycle after arm; a second arm in FIRED leaves trigger high and status 3.
- Re-arm in ARMED after 2 of 3 matches -> 3 further matches are required before trigger.
- sample_div = 3 -> sample period 4 cycles, duty 1/4; change to 0 mid-run -> continuous strobe after the current count expires.
- Reset asserted in DELAY -> the next cycle shows trigger = 0, status = 0, sample = 0, channels_out = 0.
